// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Parametrised single-clock FIFO on the display/memory request path. It queues
// WIDTH-bit words (default: 12-bit address + 8-bit data) between the
// instruction engine and the memory/display writer.
//
// Features:
//   - generic width and power-of-two depth (DEPTH >= 4)
//   - registered occupancy count plus empty/full/almost flags
//   - sticky overflow/underflow flags, cleared by err_clr
//   - optional first-word-fall-through read mode
//
// Compile-time option:
//   FIFO_FWFT_EN  defined   : first-word-fall-through. rd_data always shows the
//                             head word while !empty, rd_valid = !empty, and
//                             rd_en acknowledges and pops the head word.
//                 undefined : standard mode. rd_data/rd_valid are registered
//                             and update on the edge that accepts rd_en.
//
// Ports:
//   clk           in   1        single clock, rising-edge
//   rst_n         in   1        asynchronous active-low reset
//   wr_en         in   1        write request
//   wr_data       in   WIDTH    write word
//   rd_en         in   1        read request
//   rd_data       out  WIDTH    read word
//   rd_valid      out  1        standard: one-cycle pulse per pop
//                               FWFT: !empty
//   empty         out  1        count == 0
//   full          out  1        count == DEPTH
//   almost_empty  out  1        count <= AEMPTY_LVL
//   almost_full   out  1        count >= AFULL_LVL
//   count         out  AW+1     occupancy, 0..DEPTH
//   overflow      out  1        sticky: write while full with no read
//   underflow     out  1        sticky: read while empty
//   err_clr       in   1        clears overflow and underflow
//
// Handshake:
//   There is no back-pressure signal on either side. A write is accepted when
//   wr_en && (!full || rd_en); a read is accepted when rd_en && !empty. A
//   request that is not accepted is lost and recorded in the matching sticky
//   error flag (except for the standard-mode bypass on an empty FIFO, where a
//   simultaneous read and write hand the write word straight to rd_data).
// -----------------------------------------------------------------------------

module sync_fifo #(
    parameter  int WIDTH      = 20,
    parameter  int DEPTH      = 16,
    parameter  int AFULL_LVL  = DEPTH - 2,
    parameter  int AEMPTY_LVL = 2,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    // Count is one bit wider than the pointers so that DEPTH is representable.
    localparam int CW = AW + 1;

    localparam logic [AW:0] L_DEPTH  = CW'(DEPTH);
    localparam logic [AW:0] L_AFULL  = CW'(AFULL_LVL);
    localparam logic [AW:0] L_AEMPTY = CW'(AEMPTY_LVL);

    // -------------------------------------------------------------------------
    // Storage and pointers
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rp;
    logic [AW-1:0]    r_wp;
    logic [AW:0]      r_count;

    // Registered flags, computed from the next count so they line up with it.
    logic             r_empty;
    logic             r_full;
    logic             r_almost_empty;
    logic             r_almost_full;
    logic             r_overflow;
    logic             r_underflow;

    // -------------------------------------------------------------------------
    // Request decoding
    // -------------------------------------------------------------------------
    logic             w_rd_acc;      // a word is popped from the array
    logic             w_wr_acc;      // write permitted by the full rule
    logic             w_wr_store;    // write actually lands in the array
    logic             w_bypass;      // standard-mode empty pass-through
    logic             w_ovf_set;
    logic             w_unf_set;
    logic [AW:0]      w_count_nxt;

    assign w_rd_acc = rd_en && !r_empty;

    // While full, a write is still accepted if a read frees a slot on the same
    // edge; the count then stays at DEPTH.
    assign w_wr_acc = wr_en && (!r_full || rd_en);

`ifdef FIFO_FWFT_EN
    // In FWFT mode an empty FIFO has no head word to hand out, so a read on
    // empty is always an underflow and the write is stored normally.
    assign w_bypass = 1'b0;
`else
    // In standard mode a read and write on an empty FIFO pass the write word
    // straight to the registered output; nothing is stored.
    assign w_bypass = rd_en && wr_en && r_empty;
`endif

    assign w_wr_store = w_wr_acc && !w_bypass;

    assign w_ovf_set  = wr_en && r_full && !rd_en;
    assign w_unf_set  = rd_en && r_empty && !w_bypass;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_store && !w_rd_acc) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_wr_store && w_rd_acc) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Array write port. Contents are not reset; stale words are never visible
    // because the pointers and count are.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_store) begin
            r_mem[r_wp] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, count and occupancy flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rp           <= '0;
            r_wp           <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
        end else begin
            // Pointers are exactly AW bits wide, so DEPTH-1 wraps to 0.
            if (w_wr_store) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_rd_acc) begin
                r_rp <= r_rp + 1'b1;
            end
            r_count        <= w_count_nxt;
            r_empty        <= (w_count_nxt == '0);
            r_full         <= (w_count_nxt == L_DEPTH);
            r_almost_empty <= (w_count_nxt <= L_AEMPTY);
            r_almost_full  <= (w_count_nxt >= L_AFULL);
        end
    end

    // -------------------------------------------------------------------------
    // Sticky error flags. A fresh error on the clearing edge takes priority so
    // the event is not lost.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end

            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read output path
    // -------------------------------------------------------------------------
`ifdef FIFO_FWFT_EN
    // Head word is shown directly from the array. It comes only from
    // registered state (array + read pointer), so there is still no
    // combinational path from any input to rd_data.
    assign rd_data  = r_mem[r_rp];
    assign rd_valid = !r_empty;
`else
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_bypass) begin
                r_rd_data <= wr_data;
            end else if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rp];
            end
            // One-cycle pulse per delivered word; rd_data holds afterwards.
            r_rd_valid <= w_bypass || w_rd_acc;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif

    // -------------------------------------------------------------------------
    // Output assignments
    // -------------------------------------------------------------------------
    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
